// File: rtl/parking_display_scan.sv
// Multiplexed 7-segment scanner for the parking status panel: free-slot count on the
// right pair, first empty slot on the left pair, blinking "FULL" when no slot is free.
module parking_display_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int CAP_W        = 3,
  parameter int SLOT_W       = 2,
  parameter int DWELL        = 2,
  parameter int BLINK_FRAMES = 8
) (
  input  logic                  clk_500Hz,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [CAP_W-1:0]      capacity,
  input  logic [SLOT_W-1:0]     first_empty,
  output logic [NUM_DIGITS-1:0] anodes,
  output logic [6:0]            segments,
  output logic                  frame_start
);

  // state     | meaning
  // BLINK_ON  | FULL glyphs visible (also the idle phase in NORMAL mode)
  // BLINK_OFF | FULL glyphs blanked, anodes keep scanning
  typedef enum logic {BLINK_ON, BLINK_OFF} phase_t;

  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DWL_W = $clog2(DWELL + 1);
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [6:0] GLY_F = 7'h71;
  localparam logic [6:0] GLY_U = 7'h3E;
  localparam logic [6:0] GLY_L = 7'h38;

  phase_t                  phase, phase_n, phase_eff;
  logic [DWL_W-1:0]        dwell_cnt, dwell_cnt_n;
  logic [DIG_W-1:0]        digit_idx, digit_idx_n;
  logic [BLK_W-1:0]        blink_cnt, blink_cnt_n;
  logic [CAP_W-1:0]        shadow_cap, cap_eff;
  logic [SLOT_W-1:0]       shadow_fe, fe_eff;
  logic                    wrap, full;
  int unsigned             cap_v, slot_v;
  logic [NUM_DIGITS-1:0]   anodes_n;
  logic [6:0]              segments_n;

  function automatic logic [6:0] glyph(input int unsigned d);
    case (d)
      0:       glyph = 7'h3F;
      1:       glyph = 7'h06;
      2:       glyph = 7'h5B;
      3:       glyph = 7'h4F;
      4:       glyph = 7'h66;
      5:       glyph = 7'h6D;
      6:       glyph = 7'h7D;
      7:       glyph = 7'h07;
      8:       glyph = 7'h7F;
      9:       glyph = 7'h6F;
      default: glyph = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clk_500Hz) begin
    if (reset) begin
      phase       <= BLINK_ON;
      dwell_cnt   <= '0;
      digit_idx   <= '0;
      blink_cnt   <= '0;
      shadow_cap  <= capacity;
      shadow_fe   <= first_empty;
      anodes      <= '0;
      segments    <= '0;
      frame_start <= 1'b0;
    end else begin
      phase       <= phase_n;
      dwell_cnt   <= dwell_cnt_n;
      digit_idx   <= digit_idx_n;
      blink_cnt   <= blink_cnt_n;
      shadow_cap  <= cap_eff;
      shadow_fe   <= fe_eff;
      anodes      <= anodes_n;
      segments    <= segments_n;
      frame_start <= wrap;
    end
  end

  always_comb begin
    wrap        = enable && (digit_idx == '0) && (dwell_cnt == '0);
    cap_eff     = wrap ? capacity : shadow_cap;
    fe_eff      = wrap ? first_empty : shadow_fe;
    full        = (cap_eff == '0);
    dwell_cnt_n = dwell_cnt;
    digit_idx_n = digit_idx;
    blink_cnt_n = blink_cnt;
    phase_n     = phase;

    if (enable) begin
      if (dwell_cnt == DWL_W'(DWELL - 1)) begin
        dwell_cnt_n = '0;
        digit_idx_n = (digit_idx == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + DIG_W'(1);
      end else begin
        dwell_cnt_n = dwell_cnt + DWL_W'(1);
      end
    end

    // A wrap that enters FULL restarts the blink so the first ON period is complete.
    if (wrap && full) begin
      if (shadow_cap != '0) begin
        blink_cnt_n = '0;
        phase_n     = BLINK_ON;
      end else if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_n = '0;
        phase_n     = (phase == BLINK_ON) ? BLINK_OFF : BLINK_ON;
      end else begin
        blink_cnt_n = blink_cnt + BLK_W'(1);
      end
    end
    phase_eff = wrap ? phase_n : phase;
  end

  always_comb begin
    cap_v = 32'(cap_eff);
    if (cap_v > 99) cap_v = 99;
    slot_v     = 32'(fe_eff) + 1;
    anodes_n   = '0;
    segments_n = '0;

    if (enable) begin
      anodes_n[digit_idx] = 1'b1;
      if (full) begin
        if (phase_eff == BLINK_ON) begin
          case (32'(digit_idx))
            0, 1:    segments_n = GLY_L;
            2:       segments_n = GLY_U;
            3:       segments_n = GLY_F;
            default: segments_n = '0;
          endcase
        end
      end else begin
        case (32'(digit_idx))
          0:       segments_n = glyph(cap_v % 10);
          1:       segments_n = (cap_v / 10 == 0) ? 7'h00 : glyph(cap_v / 10);
          2:       segments_n = glyph(slot_v % 10);
          3:       segments_n = (slot_v / 10 == 0) ? 7'h00 : glyph(slot_v / 10);
          default: segments_n = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parking_display_scan.sv
// Bench for parking_display_scan: directed panel scenarios followed by random
// stimulus, all checked against a frame-level model of the display.
module tb_parking_display_scan;

  localparam int ND = 4;
  localparam int DW = 2;
  localparam int BF = 2;
  localparam int FRAME = ND * DW;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] capacity;
  logic [3:0] first_empty;
  logic [3:0] anodes;
  logic [6:0] segments;
  logic       frame_start;

  int nchecks = 0;
  int nerrors = 0;

  // model state: position within the frame, latched inputs, frames spent in FULL
  int         pos;
  int         sh_cap, sh_fe;
  int         full_frames;
  logic [6:0] seen [ND];
  int         lut [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  parking_display_scan #(
    .NUM_DIGITS(ND), .CAP_W(8), .SLOT_W(4), .DWELL(DW), .BLINK_FRAMES(BF)
  ) dut (
    .clk_500Hz(clk), .reset(reset), .enable(enable), .capacity(capacity),
    .first_empty(first_empty), .anodes(anodes), .segments(segments),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int expected_glyph(input int d);
    int c, s;
    c = (sh_cap > 99) ? 99 : sh_cap;
    s = sh_fe + 1;
    if (sh_cap == 0) begin
      if ((full_frames / BF) % 2 != 0) return 0;
      case (d)
        0, 1:    return 'h38;
        2:       return 'h3E;
        3:       return 'h71;
        default: return 0;
      endcase
    end
    case (d)
      0:       return lut[c % 10];
      1:       return (c / 10 == 0) ? 0 : lut[c / 10];
      2:       return lut[s % 10];
      3:       return (s / 10 == 0) ? 0 : lut[s / 10];
      default: return 0;
    endcase
  endfunction

  task automatic model_edge(output int ea, output int es, output int ef);
    int d;
    ea = 0; es = 0; ef = 0;
    if (reset) begin
      pos = 0; sh_cap = capacity; sh_fe = first_empty; full_frames = 0;
    end else if (enable) begin
      if (pos == 0) begin
        if (capacity == 0) full_frames = (sh_cap != 0) ? 0 : full_frames + 1;
        sh_cap = capacity;
        sh_fe  = first_empty;
      end
      d  = pos / DW;
      ea = 1 << d;
      ef = (pos == 0);
      es = expected_glyph(d);
      pos = (pos + 1) % FRAME;
    end
  endtask

  task automatic step();
    int ea, es, ef;
    @(posedge clk);
    #1;
    model_edge(ea, es, ef);
    chk("anodes", 32'(anodes), ea);
    chk("segments", 32'(segments), es);
    chk("frame_start", 32'(frame_start), ef);
  endtask

  // one aligned frame, keeping the glyph shown on each digit
  task automatic frame();
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (i % DW == 0) seen[i / DW] = segments;
    end
  endtask

  task automatic chk_frame(input string tag, input int d3, input int d2, input int d1, input int d0);
    chk({tag, "_d0"}, 32'(seen[0]), d0);
    chk({tag, "_d1"}, 32'(seen[1]), d1);
    chk({tag, "_d2"}, 32'(seen[2]), d2);
    chk({tag, "_d3"}, 32'(seen[3]), d3);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; capacity = 8'd4; first_empty = 4'd0;
    repeat (3) step();
    chk("reset_anodes", 32'(anodes), 0);

    reset = 1'b0;
    frame();
    chk_frame("cap4", 'h00, 'h06, 'h00, 'h66);
    frame();

    capacity = 8'd12; first_empty = 4'd9;
    frame();
    chk_frame("cap12", 'h06, 'h3F, 'h06, 'h5B);

    repeat (3) step();
    capacity = 8'd7;
    repeat (5) step();
    chk("cap_change_held_d1", 32'(seen[1]), 'h06);
    frame();
    chk_frame("cap7", 'h06, 'h3F, 'h00, 'h07);

    capacity = 8'd0;
    frame(); chk_frame("full_on1", 'h71, 'h3E, 'h38, 'h38);
    frame(); chk_frame("full_on2", 'h71, 'h3E, 'h38, 'h38);
    frame(); chk_frame("full_off1", 0, 0, 0, 0);
    frame(); chk_frame("full_off2", 0, 0, 0, 0);
    frame(); chk_frame("full_on3", 'h71, 'h3E, 'h38, 'h38);
    capacity = 8'd5;
    frame(); chk_frame("leave_full", 'h06, 'h3F, 'h00, 'h6D);

    capacity = 8'd150;
    frame(); chk_frame("sat150", 'h06, 'h3F, 'h6F, 'h6F);
    capacity = 8'd100;
    frame(); chk_frame("sat100", 'h06, 'h3F, 'h6F, 'h6F);

    repeat (4) step();
    enable = 1'b0;
    step();
    chk("disable_anodes", 32'(anodes), 0);
    repeat (2) step();
    enable = 1'b1;
    step();
    chk("resume_anodes", 32'(anodes), 'b0100);
    repeat (2) step();
    reset = 1'b1;
    step();
    chk("midreset_anodes", 32'(anodes), 0);
    chk("midreset_segments", 32'(segments), 0);
    reset = 1'b0;
    step();
    chk("restart_anodes", 32'(anodes), 'b0001);

    for (int i = 0; i < 1500; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      reset  = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2: capacity = 8'd0;
          3:       capacity = 8'($urandom_range(100, 255));
          default: capacity = 8'($urandom_range(1, 99));
        endcase
        first_empty = 4'($urandom_range(0, 15));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
